// File: rtl/if_fetch_queue.sv
// Instruction fetch with a DEPTH-entry {pc, inst} decoupling queue drained by decode via valid/ready.
// Head is visible 1 cycle after its fetch; when full, fetch stalls unless a pop frees a slot the same cycle.
module if_fetch_queue #(
  parameter int ADDR_W = 10,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       taken,
  input  logic [ADDR_W-1:0]          br_addr,
  input  logic                       halting,
  input  logic                       inst_ready,
  output logic                       inst_valid,
  output logic [31:0]                inst,
  output logic [ADDR_W-1:0]          inst_pc,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = ADDR_W - 2;

  logic [ADDR_W-1:0] pc;
  logic [31:0]       imem [2**IW];
  logic [31:0]       fetch_inst;

  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [31:0]       q_inst [DEPTH];

  logic pop;
  logic fetch;

  assign fetch_inst = imem[pc[ADDR_W-1:2]];

  assign inst_valid = (count != '0);
  assign pop        = inst_valid & inst_ready;
  assign fetch      = !taken && !halting && ((count < CW'(DEPTH)) || pop);

  assign inst    = inst_valid ? q_inst[head] : '0;
  assign inst_pc = inst_valid ? q_pc[head]   : '0;
  assign q_count = count;

  // A redirect discards everything queued, including an entry popped in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (taken) begin
      pc    <= {br_addr[ADDR_W-1:2], 2'b00};
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (fetch) begin
        pc   <= pc + ADDR_W'(4);
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({fetch, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: count gates visibility.
  always_ff @(posedge clk) begin
    if (fetch) begin
      q_pc[tail]   <= pc;
      q_inst[tail] <= fetch_inst;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: streaming, stall/refill, redirect, halt, PC wrap and async reset.
module tb_if_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        taken;
  logic [9:0]  br_addr;
  logic        halting;
  logic        inst_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [9:0]  inst_pc;
  logic [2:0]  q_count;

  int checks = 0;
  int failures = 0;

  if_fetch_queue #(.ADDR_W(10), .DEPTH(4), .RESET_PC(10'h000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .taken      (taken),
    .br_addr    (br_addr),
    .halting    (halting),
    .inst_ready (inst_ready),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .q_count    (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    taken      = 1'b0;
    br_addr    = '0;
    halting    = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 256; i++) dut.imem[i] = 32'h100 + i;

    // T1: reset state, then one instruction per cycle
    step(2);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_count", q_count, 0);
    chk("rst_pc", dut.pc, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk("t1_valid", inst_valid, 1);
      chk("t1_inst_pc", inst_pc, 4 * (k - 1));
      chk("t1_inst", inst, 32'h100 + k - 1);
      chk("t1_count", q_count, 1);
    end

    // T2: stall fills queue, then drain in order with full+pop
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    inst_ready = 1'b0;
    step(10);
    chk("t2_count_full", q_count, 4);
    chk("t2_pc_stop", dut.pc, 10'h010);
    chk("t2_head_stable", inst_pc, 0);
    chk("t2_inst_stable", inst, 32'h100);
    inst_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      chk("t2_inst_pc", inst_pc, 4 * k);
      chk("t2_count", q_count, 4);
    end

    // T3: redirect with 3 queued entries
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    inst_ready = 1'b0;
    step(3);
    chk("t3_count3", q_count, 3);
    taken = 1'b1;
    br_addr = 10'h203;
    step(1);
    taken = 1'b0;
    chk("t3_valid", inst_valid, 0);
    chk("t3_count", q_count, 0);
    chk("t3_pc", dut.pc, 10'h200);
    step(1);
    chk("t3_inst_pc", inst_pc, 10'h200);
    chk("t3_inst", inst, 32'h180);

    // T4: halting drains queue with PC frozen; taken overrides halting
    step(2);
    chk("t4_count3", q_count, 3);
    halting = 1'b1;
    inst_ready = 1'b1;
    step(1);
    chk("t4_pop_while_halt", inst_pc, 10'h204);
    step(4);
    chk("t4_count", q_count, 0);
    chk("t4_valid", inst_valid, 0);
    chk("t4_pc_frozen", dut.pc, 10'h20C);
    taken = 1'b1;
    br_addr = 10'h040;
    step(1);
    chk("t4_redirect_pc", dut.pc, 10'h040);
    chk("t4_redirect_count", q_count, 0);
    taken = 1'b0;
    halting = 1'b0;
    step(1);
    chk("t4_inst_pc", inst_pc, 10'h040);
    chk("t4_inst", inst, 32'h110);

    // T5: PC wrap at top of address space
    taken = 1'b1;
    br_addr = 10'h3F8;
    step(1);
    taken = 1'b0;
    chk("t5_pc", dut.pc, 10'h3F8);
    step(1);
    chk("t5_pc_3f8", inst_pc, 10'h3F8);
    chk("t5_inst_3f8", inst, 32'h1FE);
    step(1);
    chk("t5_pc_3fc", inst_pc, 10'h3FC);
    chk("t5_pc_wrap", dut.pc, 10'h000);
    step(1);
    chk("t5_inst_pc_wrap", inst_pc, 10'h000);
    chk("t5_inst_wrap", inst, 32'h100);

    // T6: asynchronous reset with a full queue
    inst_ready = 1'b0;
    step(3);
    chk("t6_full", q_count, 4);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", inst_valid, 0);
    chk("t6_inst", inst, 0);
    chk("t6_inst_pc", inst_pc, 0);
    chk("t6_count", q_count, 0);
    chk("t6_pc", dut.pc, 0);
    step(1);
    rst_n = 1'b1;
    inst_ready = 1'b1;
    step(1);
    chk("t6_first_pc", inst_pc, 0);
    chk("t6_first_inst", inst, 32'h100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
